// File: rtl/calc_pkg.sv
// Shared definitions for the postfix calculator front end and the calculator
// itself: token opcodes, the ASCII characters the tokenizer understands, the
// tokenizer state encoding and small character-classification helpers.
package calc_pkg;

  // Tokenizer states. IDLE: between tokens. NEG: a '-' was seen. NUM: digits
  // are being accumulated. HOLD: a push token was just emitted and the
  // delimiter that ended the number waits in hold_ch.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NEG  = 2'd1,
    ST_NUM  = 2'd2,
    ST_HOLD = 2'd3
  } tok_state_t;

  typedef enum logic [2:0] {
    CC_OP    = 3'd0,
    CC_SEP   = 3'd1,
    CC_MINUS = 3'd2,
    CC_DIGIT = 3'd3,
    CC_BAD   = 3'd4
  } char_class_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_MUL  = 3'b001;
  localparam logic [2:0] OP_LPAR = 3'b010;
  localparam logic [2:0] OP_RPAR = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_EQ   = 3'b101;

  localparam logic [7:0] ASC_PLUS  = 8'h2B;
  localparam logic [7:0] ASC_STAR  = 8'h2A;
  localparam logic [7:0] ASC_LPAR  = 8'h28;
  localparam logic [7:0] ASC_RPAR  = 8'h29;
  localparam logic [7:0] ASC_EQ    = 8'h3D;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_TAB   = 8'h09;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_NINE  = 8'h39;

  function automatic char_class_t classify(input logic [7:0] ch);
    char_class_t cc;
    cc = CC_BAD;
    if (ch >= ASC_ZERO && ch <= ASC_NINE) cc = CC_DIGIT;
    else if (ch == ASC_MINUS) cc = CC_MINUS;
    else if (ch == ASC_SPACE || ch == ASC_TAB || ch == ASC_CR || ch == ASC_LF) cc = CC_SEP;
    else if (ch == ASC_PLUS || ch == ASC_STAR || ch == ASC_LPAR ||
             ch == ASC_RPAR || ch == ASC_EQ) cc = CC_OP;
    return cc;
  endfunction

  // Opcode of a single-character operator; meaningless for other classes.
  function automatic logic [2:0] op_of(input logic [7:0] ch);
    logic [2:0] op;
    op = OP_ADD;
    case (ch)
      ASC_STAR: op = OP_MUL;
      ASC_LPAR: op = OP_LPAR;
      ASC_RPAR: op = OP_RPAR;
      ASC_EQ:   op = OP_EQ;
      default:  op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/digit_acc.sv
// Decimal accumulator step: result = base*10 +/- digit, where base is 0 when
// start is set (first digit of a number) and acc otherwise. neg selects a
// negative number, which is built by subtracting each digit.
// Build option TOK_SAT_EN: out-of-range results saturate to the signed
// DATA_W limits and ovf pulses; otherwise the result wraps modulo 2^DATA_W
// and ovf stays 0.
// Ports: acc (current value), digit (0..9), start, neg -> result, ovf.
module digit_acc #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [3:0]        digit,
  input  logic              start,
  input  logic              neg,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

`ifdef TOK_SAT_EN
  // Five guard bits hold any value of base*10 +/- 9 without loss.
  localparam int W = DATA_W + 5;

  logic signed [W-1:0] base, times10, dext, sum, maxv, minv;

  assign base    = start ? '0 : {{5{acc[DATA_W-1]}}, acc};
  assign times10 = (base <<< 3) + (base <<< 1);
  assign dext    = {{(W-4){1'b0}}, digit};
  assign sum     = neg ? (times10 - dext) : (times10 + dext);
  assign maxv    = {{6{1'b0}}, {(DATA_W-1){1'b1}}};
  assign minv    = {{6{1'b1}}, {(DATA_W-1){1'b0}}};

  always_comb begin
    ovf    = 1'b0;
    result = sum[DATA_W-1:0];
    if (sum > maxv) begin
      result = {1'b0, {(DATA_W-1){1'b1}}};
      ovf    = 1'b1;
    end else if (sum < minv) begin
      result = {1'b1, {(DATA_W-1){1'b0}}};
      ovf    = 1'b1;
    end
  end
`else
  logic [DATA_W-1:0] base, times10, dext;

  assign base    = start ? '0 : acc;
  assign times10 = (base << 3) + (base << 1);
  assign dext    = {{(DATA_W-4){1'b0}}, digit};
  assign result  = neg ? (times10 - dext) : (times10 + dext);
  assign ovf     = 1'b0;
`endif

endmodule

// File: rtl/expr_tokenizer.sv
// Lexer for the postfix calculator: turns an ASCII character stream into
// calculator tokens (operators, '=', and signed push operands).
// Build option TOK_SAT_EN (in digit_acc): saturate oversized numbers and
// flag err instead of wrapping.
// Ports: clk, rst (async, active high); char_in/char_valid/char_ready input
// stream; tok_opcode/tok_operand/tok_valid/tok_ready token stream; err sticky
// error flag; dbg_state current FSM state.
// Handshake: both streams transfer on a cycle where valid && ready are high
// at the rising edge; a presented token stays unchanged until it transfers.
module expr_tokenizer
  import calc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        char_in,
  input  logic              char_valid,
  output logic              char_ready,
  output logic [2:0]        tok_opcode,
  output logic [DATA_W-1:0] tok_operand,
  output logic              tok_valid,
  input  logic              tok_ready,
  output logic              err,
  output tok_state_t        dbg_state
);

  tok_state_t        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_next;
  logic              neg_q;
  logic [7:0]        hold_ch;
  logic              char_acc, tok_take, acc_ovf;
  char_class_t       cls, hcls;

  logic              tok_load, err_set, acc_en, acc_start, acc_neg, hold_load;
  logic [2:0]        tok_op_d;
  logic [DATA_W-1:0] tok_val_d;

  assign char_ready = (state_q != ST_HOLD) && (!tok_valid || tok_ready);
  assign char_acc   = char_valid && char_ready;
  assign tok_take   = tok_valid && tok_ready;
  assign cls        = classify(char_in);
  assign hcls       = classify(hold_ch);
  assign dbg_state  = state_q;

  digit_acc #(.DATA_W(DATA_W)) u_acc (
    .acc    (acc_q),
    .digit  (char_in[3:0]),
    .start  (acc_start),
    .neg    (acc_neg),
    .result (acc_next),
    .ovf    (acc_ovf)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (char_acc) begin
        if (cls == CC_MINUS)      state_d = ST_NEG;
        else if (cls == CC_DIGIT) state_d = ST_NUM;
      end
      ST_NEG: if (char_acc) begin
        // A second '-' is itself a fresh sign candidate.
        if (cls == CC_DIGIT)      state_d = ST_NUM;
        else if (cls != CC_MINUS) state_d = ST_IDLE;
      end
      ST_NUM: if (char_acc) begin
        if (cls == CC_BAD)        state_d = ST_IDLE;
        else if (cls != CC_DIGIT) state_d = ST_HOLD;
      end
      ST_HOLD: if (tok_take) begin
        state_d = (hcls == CC_MINUS) ? ST_NEG : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath control
  always_comb begin
    tok_load  = 1'b0;
    tok_op_d  = OP_ADD;
    tok_val_d = '0;
    err_set   = 1'b0;
    acc_en    = 1'b0;
    acc_start = 1'b0;
    acc_neg   = neg_q;
    hold_load = 1'b0;
    case (state_q)
      ST_IDLE: if (char_acc) begin
        if (cls == CC_OP) begin
          tok_load = 1'b1;
          tok_op_d = op_of(char_in);
        end else if (cls == CC_DIGIT) begin
          acc_en    = 1'b1;
          acc_start = 1'b1;
          acc_neg   = 1'b0;
        end else if (cls == CC_BAD) begin
          err_set = 1'b1;
        end
      end
      ST_NEG: if (char_acc) begin
        if (cls == CC_DIGIT) begin
          acc_en    = 1'b1;
          acc_start = 1'b1;
          acc_neg   = 1'b1;
        end else begin
          // Dangling sign; the character itself is handled as from IDLE.
          err_set = 1'b1;
          if (cls == CC_OP) begin
            tok_load = 1'b1;
            tok_op_d = op_of(char_in);
          end
        end
      end
      ST_NUM: if (char_acc) begin
        if (cls == CC_DIGIT) begin
          acc_en  = 1'b1;
          err_set = acc_ovf;
        end else begin
          // Any non-digit ends the number. A bad character still flags err
          // and is dropped; a real delimiter is parked until the push leaves.
          tok_load  = 1'b1;
          tok_op_d  = OP_PUSH;
          tok_val_d = acc_q;
          err_set   = (cls == CC_BAD);
          hold_load = (cls != CC_BAD);
        end
      end
      ST_HOLD: if (tok_take && hcls == CC_OP) begin
        tok_load = 1'b1;
        tok_op_d = op_of(hold_ch);
      end
      default: ;
    endcase
  end

  // Datapath and token register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      neg_q       <= 1'b0;
      hold_ch     <= 8'h00;
      tok_valid   <= 1'b0;
      tok_opcode  <= OP_ADD;
      tok_operand <= '0;
      err         <= 1'b0;
    end else begin
      if (acc_en) acc_q <= acc_next;
      if (acc_en && acc_start) neg_q <= acc_neg;
      if (hold_load) hold_ch <= char_in;
      if (tok_load) begin
        tok_valid   <= 1'b1;
        tok_opcode  <= tok_op_d;
        tok_operand <= tok_val_d;
      end else if (tok_take) begin
        tok_valid <= 1'b0;
      end
      if (err_set) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_expr_tokenizer.sv
// Bench for expr_tokenizer: table of character strings with the token list
// and final err each must produce, plus cycle-level sequences for HOLD,
// downstream backpressure and mid-number reset.
module tb_expr_tokenizer;
  import calc_pkg::*;

  localparam int DATA_W = 8;

  logic              clk, rst;
  logic [7:0]        char_in;
  logic              char_valid, char_ready;
  logic [2:0]        tok_opcode;
  logic [DATA_W-1:0] tok_operand;
  logic              tok_valid, tok_ready, err;
  tok_state_t        dbg_state;

  expr_tokenizer #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .tok_opcode (tok_opcode),
    .tok_operand(tok_operand),
    .tok_valid  (tok_valid),
    .tok_ready  (tok_ready),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [10:0] exp_q[$];   // expected {opcode, operand} in order

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst        = 1'b1;
    char_valid = 1'b0;
    char_in    = 8'h00;
    tok_ready  = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Driver: present one character and wait (bounded) until it is taken.
  task automatic send_char(input logic [7:0] c);
    int n;
    logic taken;
    n = 0;
    taken = 1'b0;
    char_in    = c;
    char_valid = 1'b1;
    do begin
      @(negedge clk);
      taken = char_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!taken && n < 20);
    char_valid = 1'b0;
    if (!taken) chk($sformatf("send_timeout_%02h", c), 32'd0, 32'd1);
  endtask

  task automatic drain(input string name, input logic exp_err);
    repeat (6) @(posedge clk);
    #1;
    chk({name, "_leftover_tokens"}, exp_q.size(), 0);
    chk({name, "_err"}, err, exp_err);
  endtask

  // Scoreboard: every token that transfers is matched against exp_q.
  always @(negedge clk) begin
    if (!rst && tok_valid && tok_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_token: got %03h, expected none", {tok_opcode, tok_operand});
      end else begin
        chk("token", {21'd0, tok_opcode, tok_operand}, {21'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  typedef struct {
    string       text;
    int          ntok;
    logic [87:0] toks;    // first token in the most significant used slot
    logic        exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic set_vec(input int i, input string t, input int n,
                         input logic [87:0] tk, input logic e);
    vecs[i].text    = t;
    vecs[i].ntok    = n;
    vecs[i].toks    = tk;
    vecs[i].exp_err = e;
  endtask

  initial begin
    set_vec(0, "( 2 3 * )=", 6, {11'h200, 11'h402, 11'h403, 11'h100, 11'h300, 11'h500}, 1'b0);
    set_vec(1, "-20 5+",     3, {11'h4EC, 11'h405, 11'h000}, 1'b0);
`ifdef TOK_SAT_EN
    set_vec(2, "200 ",       1, {11'h47F}, 1'b1);
`else
    set_vec(2, "200 ",       1, {11'h4C8}, 1'b0);
`endif
    set_vec(3, "4#+",        2, {11'h404, 11'h000}, 1'b1);
    set_vec(4, "-+",         1, {11'h000}, 1'b1);
    set_vec(5, "+*=",        3, {11'h000, 11'h100, 11'h500}, 1'b0);
    set_vec(6, "-128 127 ",  2, {11'h480, 11'h47F}, 1'b0);
    set_vec(7, "3\t4\r\n=",  3, {11'h403, 11'h404, 11'h500}, 1'b0);
    set_vec(8, "0=",         2, {11'h400, 11'h500}, 1'b0);

    // Reset state
    reset_dut();
    @(negedge clk);
    chk("rst_char_ready", char_ready, 1);
    chk("rst_tok_valid", tok_valid, 0);
    chk("rst_opcode", tok_opcode, 0);
    chk("rst_operand", tok_operand, 0);
    chk("rst_err", err, 0);
    chk("rst_state", dbg_state, ST_IDLE);

    // Table-driven strings with tok_ready held high
    for (int i = 0; i < 9; i++) begin
      reset_dut();
      for (int k = 0; k < vecs[i].ntok; k++)
        exp_q.push_back(vecs[i].toks[(vecs[i].ntok-1-k)*11 +: 11]);
      for (int j = 0; j < vecs[i].text.len(); j++)
        send_char(vecs[i].text[j]);
      drain($sformatf("vec%0d", i), vecs[i].exp_err);
    end

    // HOLD: '+' waits one cycle behind the push with char_ready low
    reset_dut();
    exp_q.push_back(11'h4EC);
    exp_q.push_back(11'h405);
    exp_q.push_back(11'h000);
    send_char("-"); send_char("2"); send_char("0");
    send_char(" "); send_char("5"); send_char("+");
    char_in = " ";
    char_valid = 1'b1;
    @(negedge clk);
    chk("hold_char_ready", char_ready, 0);
    chk("hold_state", dbg_state, ST_HOLD);
    chk("hold_push", {tok_valid, tok_opcode, tok_operand}, 12'hC05);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_plus", {tok_valid, tok_opcode, tok_operand}, 12'h800);
    chk("hold_release_ready", char_ready, 1);
    chk("hold_release_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    char_valid = 1'b0;
    drain("hold_seq", 1'b0);

    // Backpressure: push 07 held for three cycles of tok_ready low
    reset_dut();
    tok_ready = 1'b0;
    exp_q.push_back(11'h407);
    exp_q.push_back(11'h100);
    send_char("7");
    send_char("*");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_tok", c), {tok_valid, tok_opcode, tok_operand}, 12'hC07);
      chk($sformatf("stall%0d_ready", c), char_ready, 0);
      @(posedge clk); #1;
    end
    tok_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_release_tok", {tok_valid, tok_opcode, tok_operand}, 12'h900);
    drain("stall_seq", 1'b0);

    // Reset in the middle of a number
    reset_dut();
    send_char("1");
    send_char("2");
    #2 rst = 1'b1;
    #1;
    chk("midrst_tok_valid", tok_valid, 0);
    chk("midrst_opcode", tok_opcode, 0);
    chk("midrst_operand", tok_operand, 0);
    chk("midrst_err", err, 0);
    chk("midrst_state", dbg_state, ST_IDLE);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_char_ready", char_ready, 1);
    @(posedge clk); #1;
    exp_q.push_back(11'h403);
    send_char("3");
    send_char(" ");
    drain("midrst_seq", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
